prm_oblgc_sop_engine: RTL
=========================

Name: prm_oblgc_sop_engine

Overview:
- Programmable, sequential successor to the fixed per-edge obstacle-logic checkers.
- Each edge's combinational truth table is replaced by a run-time-loaded sum-of-products table of NTERMS (care, value) product terms.
- Each edge query carries an IN_W-bit occupancy vector. The engine scans the table TPC terms per cycle, exits early on the first hit, and returns edge_mask together with the index of the matching term.
- Sits between the PRM edge/voxel sequencer and the roadmap edge-mask store. Keeps masked/total edge statistics.

Parameters:
- IN_W, 15, occupancy vector width (inputs A..O map to bits 0..14).
- NTERMS, 128, product-term capacity; power of 2.
- TPC, 8, terms evaluated per cycle; power of 2, divides NTERMS.
- ID_W, 16, edge identifier width.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- cfg_we  in  1  term write strobe.
- cfg_addr  in  log2(NTERMS)  term index.
- cfg_care  in  IN_W  care mask; 1 = bit participates.
- cfg_val  in  IN_W  required bit values.
- cfg_en  in  1  term enable.
- cfg_ready  out  1  high when writes are accepted.
- in_valid  in  1  query valid.
- in_ready  out  1  query accept.
- in_vec  in  IN_W  occupancy vector.
- in_id  in  ID_W  edge id.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_mask  out  1  1 = edge blocked.
- out_hit_idx  out  log2(NTERMS)  lowest matching term; 0 when out_mask=0.
- out_id  out  ID_W  echoed edge id.
- clr_cnt  in  1  synchronous clear of both counters.
- total_cnt  out  CNT_W  results delivered.
- masked_cnt  out  CNT_W  results delivered with out_mask=1.

Behaviour:
- Term t matches when en[t]=1 and ((vec ^ val[t]) & care[t]) == 0. A term with care=0 and en=1 matches every vector.
- Reset:
  - state=IDLE; all en[t]=0, so every query returns out_mask=0. care/val storage is not reset.
  - out_valid=0, out_mask=0, out_hit_idx=0, out_id=0, total_cnt=0, masked_cnt=0.
  - in_ready=1 and cfg_ready=1 once reset deasserts.
- Reset mid-scan or mid-hold: the query is abandoned with no output and no counter change.
- FSM:
  - IDLE: in_ready=1, cfg_ready=1. When in_valid=1, latch in_vec and in_id, set group=0, go to SCAN.
  - SCAN: in_ready=0, cfg_ready=0. Evaluate terms group*TPC .. group*TPC+TPC-1.
    - Any match: register out_mask=1 and out_hit_idx = lowest matching index; go to DONE.
    - No match and group is the last (NTERMS/TPC-1): register out_mask=0, out_hit_idx=0; go to DONE.
    - Otherwise: group+1, stay in SCAN.
  - DONE: out_valid=1. out_mask, out_hit_idx and out_id are held stable while out_ready=0. When out_ready=1, go to IDLE.
- Latency from accept cycle k to out_valid: k+g+2 when hit in group g; k+NTERMS/TPC+1 on a miss.
  - Minimum is 2 cycles.
  - Default parameters: 17 cycles on a miss.
- Throughput: one query in flight. in_ready returns the cycle after the out handshake.
- Config:
  - Writes are applied only when cfg_we=1 and cfg_ready=1.
  - A cfg_we with cfg_ready=0 is dropped. The master must hold cfg_we until it sees cfg_ready=1.
  - A write and a query accept in the same IDLE cycle: the write lands first, and the query scan sees the new term.
  - Rewriting an index overwrites care, val and en together.
- Counters, updated on the out handshake:
  - total_cnt+1 on every handshake; masked_cnt+1 when out_mask=1 as well.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt zeroes both and has priority over a same-cycle increment.
- in_vec and in_id may change freely once accepted; the engine works only on the latched copy.

Test Plan:
1. Reset, then query vec=0x7FFF id=5 with no config written -> out_mask=0, out_hit_idx=0, out_id=5, out_valid at accept+17 (defaults), total_cnt=1, masked_cnt=0.
2. Write term 3: care=0x4000, val=0x0000, en=1 (matches !O). Query vec=0x3FFF -> mask=1, hit_idx=3, out_valid at accept+2. Query vec=0x4000 -> mask=0.
3. Write terms 20 and 9 both matching vec=0x0123 -> hit_idx=9, latency accept+3 (group 1). Disable term 9 -> hit_idx=20, latency accept+4 (group 2).
4. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, cfg_we pulse dropped (term unchanged on readback query). Release out_ready -> in_ready=1 next cycle.
5. Assert rst mid-SCAN at group 4 -> out_valid=0 and counters 0 immediately. After release, the previous hit term no longer masks (en cleared).
6. Preset counters near saturation with CNT_W=4: after 15 masked results, further handshakes keep 15. clr_cnt coincident with a handshake -> both counters 0.

Source files
------------

// File: rtl/prm_oblgc_sop_engine.sv
// Programmable sum-of-products obstacle checker for PRM edges: scans a run-time
// loaded table of (care, value) product terms TPC per cycle, stopping on the first hit.
module prm_oblgc_sop_engine #(
    parameter int unsigned IN_W   = 15,
    parameter int unsigned NTERMS = 128,
    parameter int unsigned TPC    = 8,
    parameter int unsigned ID_W   = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(NTERMS)-1:0] cfg_addr,
    input  logic [IN_W-1:0]           cfg_care,
    input  logic [IN_W-1:0]           cfg_val,
    input  logic                      cfg_en,
    output logic                      cfg_ready,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           in_vec,
    input  logic [ID_W-1:0]           in_id,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mask,
    output logic [$clog2(NTERMS)-1:0] out_hit_idx,
    output logic [ID_W-1:0]           out_id,
    input  logic                      clr_cnt,
    output logic [CNT_W-1:0]          total_cnt,
    output logic [CNT_W-1:0]          masked_cnt
);

    localparam int unsigned AW   = $clog2(NTERMS);
    localparam int unsigned NGRP = NTERMS / TPC;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     group_q, group_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              valid_d, mask_d, rdy_q, rdy_d;
    logic [AW-1:0]     hidx_d;
    logic [ID_W-1:0]   oid_d;

    logic [IN_W-1:0]   care_mem [NTERMS];
    logic [IN_W-1:0]   val_mem  [NTERMS];
    logic [NTERMS-1:0] en_q;

    logic              cfg_wr;
    logic              grp_hit_c;
    logic [AW-1:0]     grp_idx_c;
    logic [AW-1:0]     term_c;
    logic              out_hs;

    assign cfg_ready = rdy_q;
    assign in_ready  = rdy_q;
    assign cfg_wr    = cfg_we & rdy_q;
    assign out_hs    = out_valid & out_ready;

    // Term payload storage; deliberately not reset, enables gate its use.
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            care_mem[cfg_addr] <= cfg_care;
            val_mem[cfg_addr]  <= cfg_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
        end else if (cfg_wr) begin
            en_q[cfg_addr] <= cfg_en;
        end
    end

    // Evaluate the current group; descending walk leaves the lowest matching index.
    always_comb begin
        grp_hit_c = 1'b0;
        grp_idx_c = '0;
        term_c    = '0;
        for (int i = int'(TPC) - 1; i >= 0; i--) begin
            term_c = AW'(32'(group_q) * TPC + 32'(i));
            if (en_q[term_c] && (((vec_q ^ val_mem[term_c]) & care_mem[term_c]) == '0)) begin
                grp_hit_c = 1'b1;
                grp_idx_c = term_c;
            end
        end
    end

    // Next-state and registered-output intent.
    always_comb begin
        state_d = state_q;
        group_d = group_q;
        vec_d   = vec_q;
        id_d    = id_q;
        mask_d  = out_mask;
        hidx_d  = out_hit_idx;
        oid_d   = out_id;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d   = in_vec;
                    id_d    = in_id;
                    group_d = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (grp_hit_c) begin
                    mask_d  = 1'b1;
                    hidx_d  = grp_idx_c;
                    oid_d   = id_q;
                    state_d = S_DONE;
                end else if (group_q == GW'(NGRP - 1)) begin
                    mask_d  = 1'b0;
                    hidx_d  = '0;
                    oid_d   = id_q;
                    state_d = S_DONE;
                end else begin
                    group_d = GW'(group_q + 1'b1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d = (state_d == S_DONE);
        rdy_d   = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            group_q     <= '0;
            vec_q       <= '0;
            id_q        <= '0;
            rdy_q       <= 1'b1;
            out_valid   <= 1'b0;
            out_mask    <= 1'b0;
            out_hit_idx <= '0;
            out_id      <= '0;
        end else begin
            state_q     <= state_d;
            group_q     <= group_d;
            vec_q       <= vec_d;
            id_q        <= id_d;
            rdy_q       <= rdy_d;
            out_valid   <= valid_d;
            out_mask    <= mask_d;
            out_hit_idx <= hidx_d;
            out_id      <= oid_d;
        end
    end

    // Saturating statistics; clear wins over a same-cycle handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cnt  <= '0;
            masked_cnt <= '0;
        end else if (clr_cnt) begin
            total_cnt  <= '0;
            masked_cnt <= '0;
        end else if (out_hs) begin
            if (total_cnt != CNT_MAX) begin
                total_cnt <= total_cnt + CNT_W'(1);
            end
            if (out_mask && (masked_cnt != CNT_MAX)) begin
                masked_cnt <= masked_cnt + CNT_W'(1);
            end
        end
    end

endmodule
